// File: rtl/fifo_reader.sv
// fifo_reader: drains the bootstrap FIFO into consecutive program-memory words; optional running sum under FIFOREADER_CHECKSUM_EN.
// Latency: 3 cycles per word (POP, CAPTURE, WRITE) when unstalled; waits while the FIFO is empty and holds each write until memack.
module fifo_reader #(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      fiforeader_clk_i,
  input  logic                      fiforeader_rstn_i,
  input  logic                      fiforeader_start_i,
  input  logic [MEM_ADDR_WIDTH-1:0] fiforeader_baseaddr_i,
  input  logic [MEM_ADDR_WIDTH-1:0] fiforeader_length_i,
  input  logic                      fiforeader_emptyflag_i,
  input  logic [DATA_WIDTH-1:0]     fiforeader_readdata_i,
  output logic                      fiforeader_readflag_o,
  output logic [MEM_ADDR_WIDTH-1:0] fiforeader_memaddr_o,
  output logic [DATA_WIDTH-1:0]     fiforeader_memdata_o,
  output logic                      fiforeader_memwe_o,
  input  logic                      fiforeader_memack_i,
  output logic                      fiforeader_busy_o,
  output logic                      fiforeader_done_o
`ifdef FIFOREADER_CHECKSUM_EN
  ,
  output logic [31:0]               fiforeader_checksum_o
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_CAPTURE,
    ST_WRITE,
    ST_DONE
  } state_t;

  localparam logic [MEM_ADDR_WIDTH-1:0] ONE = MEM_ADDR_WIDTH'(1);

  state_t                    state;
  logic [MEM_ADDR_WIDTH-1:0] remaining;

  // Pop only when the FIFO has data; POP lasts a single cycle once it does.
  assign fiforeader_readflag_o = (state == ST_POP) && !fiforeader_emptyflag_i;

  always_ff @(posedge fiforeader_clk_i or negedge fiforeader_rstn_i) begin
    if (!fiforeader_rstn_i) begin
      state                <= ST_IDLE;
      remaining            <= '0;
      fiforeader_memaddr_o <= '0;
      fiforeader_memdata_o <= '0;
      fiforeader_memwe_o   <= 1'b0;
      fiforeader_busy_o    <= 1'b0;
      fiforeader_done_o    <= 1'b0;
    end else begin
      fiforeader_done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fiforeader_start_i) begin
            if (fiforeader_length_i != '0) begin
              fiforeader_memaddr_o <= fiforeader_baseaddr_i;
              remaining            <= fiforeader_length_i;
              fiforeader_busy_o    <= 1'b1;
              state                <= ST_POP;
            end else begin
              fiforeader_done_o <= 1'b1;
              state             <= ST_DONE;
            end
          end
        end
        ST_POP: begin
          if (!fiforeader_emptyflag_i) state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          fiforeader_memdata_o <= fiforeader_readdata_i;
          fiforeader_memwe_o   <= 1'b1;
          state                <= ST_WRITE;
        end
        ST_WRITE: begin
          if (fiforeader_memack_i) begin
            fiforeader_memwe_o   <= 1'b0;
            fiforeader_memaddr_o <= fiforeader_memaddr_o + ONE;
            remaining            <= remaining - ONE;
            if (remaining == ONE) begin
              fiforeader_busy_o <= 1'b0;
              fiforeader_done_o <= 1'b1;
              state             <= ST_DONE;
            end else begin
              state <= ST_POP;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FIFOREADER_CHECKSUM_EN
  // Sum of accepted writes; survives DONE so software can read it afterwards.
  always_ff @(posedge fiforeader_clk_i or negedge fiforeader_rstn_i) begin
    if (!fiforeader_rstn_i) begin
      fiforeader_checksum_o <= '0;
    end else if (state == ST_IDLE && fiforeader_start_i) begin
      fiforeader_checksum_o <= '0;
    end else if (state == ST_WRITE && fiforeader_memack_i) begin
      fiforeader_checksum_o <= fiforeader_checksum_o + 32'(fiforeader_memdata_o);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: queue-based FIFO and memory model, directed corner cases then randomized transfers.
module tb_fifo_reader;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [9:0]  base, len;
  logic        empty;
  logic [31:0] rdata;
  logic        ack;
  logic        rf, we, busy, done;
  logic [9:0]  memaddr;
  logic [31:0] memdata;
`ifdef FIFOREADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  fifo_reader #(.MEM_ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .fiforeader_clk_i       (clk),
    .fiforeader_rstn_i      (rstn),
    .fiforeader_start_i     (start),
    .fiforeader_baseaddr_i  (base),
    .fiforeader_length_i    (len),
    .fiforeader_emptyflag_i (empty),
    .fiforeader_readdata_i  (rdata),
    .fiforeader_readflag_o  (rf),
    .fiforeader_memaddr_o   (memaddr),
    .fiforeader_memdata_o   (memdata),
    .fiforeader_memwe_o     (we),
    .fiforeader_memack_i    (ack),
    .fiforeader_busy_o      (busy),
    .fiforeader_done_o      (done)
`ifdef FIFOREADER_CHECKSUM_EN
    ,
    .fiforeader_checksum_o  (checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] fifo_q[$];
  logic [31:0] pending[$];
  logic [31:0] model_words[$];
  logic [31:0] word_src[$];
  int          pend_hold = 0, pend_gap = 0;
  int          ack_delay = 0, stall_cnt = 0;
  bit          rf_s = 0, rf_prev = 0, we_prev = 0, ack_prev = 0;
  logic [9:0]  addr_prev = '0;
  logic [31:0] data_prev = '0;
  logic [9:0]  exp_addr = '0;
  int          wr_cnt = 0, cur_len = 0, pops = 0, done_cyc = 0, start_cyc = 0;
  bit          xfer_active = 0, done_exp = 0, done_seen = 0;
  logic [31:0] model_sum = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_readflag"}, rf, 0);
    check({tag, "_memwe"}, we, 0);
    check({tag, "_memaddr"}, memaddr, 0);
    check({tag, "_memdata"}, memdata, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
`ifdef FIFOREADER_CHECKSUM_EN
    check({tag, "_checksum"}, checksum, 0);
`endif
  endtask

  // FIFO side: pops follow the pulse seen before the edge; pending words trickle in.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rf_s && rstn) begin
        if (fifo_q.size() == 0) check("pop_from_empty", 1, 0);
        else begin
          rdata = fifo_q.pop_front();
          pops++;
        end
      end
      rf_s = 0;
      if (pend_hold > 0) pend_hold--;
      else if (pending.size() > 0) begin
        fifo_q.push_back(pending.pop_front());
        pend_hold = $urandom_range(pend_gap, 0);
      end
      empty = (fifo_q.size() == 0);
    end
  end

  // Memory side and protocol rules, evaluated mid-cycle.
  initial begin
    logic [31:0] w;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        rf_prev = 0; we_prev = 0; ack_prev = 0; stall_cnt = 0; ack = 0; rf_s = 0;
      end else begin
        check("rf_while_empty", rf && empty, 0);
        check("rf_consecutive", rf && rf_prev, 0);
        check("rf_during_write", rf && we, 0);
        check("done_and_busy", done && busy, 0);
        check("busy", busy, xfer_active);
        check("done", done, done_exp);
        done_exp = 0;
        if (done) begin
          done_seen = 1;
          done_cyc  = cyc;
        end
        if (we_prev && !ack_prev && we) begin
          check("stall_addr_hold", memaddr, addr_prev);
          check("stall_data_hold", memdata, data_prev);
        end
        if (we) begin
          ack = (stall_cnt >= ack_delay);
          stall_cnt = ack ? 0 : stall_cnt + 1;
        end else begin
          ack = 0;
          stall_cnt = 0;
        end
        if (we && ack) begin
          check("wr_addr", memaddr, exp_addr);
          if (model_words.size() == 0) check("wr_unexpected", 1, 0);
          else begin
            w = model_words.pop_front();
            check("wr_data", memdata, w);
            model_sum += w;
          end
          exp_addr++;
          wr_cnt++;
          if (wr_cnt == cur_len) begin
            xfer_active = 0;
            done_exp    = 1;
          end
        end
        rf_s = rf; rf_prev = rf; we_prev = we; ack_prev = ack;
        addr_prev = memaddr; data_prev = memdata;
      end
    end
  end

  // Called at posedge+2; returns at posedge+2 with the DUT back in IDLE.
  task automatic run_xfer(input logic [9:0] b, input logic [9:0] l, input int preload,
                          input int adly, input int hold, input int gap, input bit chk_lat);
    logic [31:0] w;
    int t;
    ack_delay = adly; pend_gap = gap; pend_hold = hold;
    for (int i = 0; i < int'(l); i++) begin
      if (word_src.size() > 0) w = word_src.pop_front();
      else w = $urandom;
      model_words.push_back(w);
      if (i < preload) fifo_q.push_back(w);
      else pending.push_back(w);
    end
    empty = (fifo_q.size() == 0);
    exp_addr = b; wr_cnt = 0; cur_len = int'(l); pops = 0; done_seen = 0;
    base = b; len = l; start = 1; start_cyc = cyc;
    @(posedge clk); #2;
    start = 0; base = 10'($urandom); len = 10'($urandom);
    xfer_active = (l != 0); done_exp = (l == 0); model_sum = '0;
    t = 0;
    while (!done_seen && t < 3000) begin
      start = xfer_active && ($urandom_range(7, 0) == 0);
      @(posedge clk); #2;
      t++;
    end
    start = 0;
    check("done_seen", done_seen, 1);
    if (chk_lat) check("done_latency", done_cyc - start_cyc, 3 * int'(l) + 1);
    check("write_count", wr_cnt, l);
    check("pop_count", pops, l);
`ifdef FIFOREADER_CHECKSUM_EN
    check("checksum", checksum, model_sum);
`endif
  endtask

  initial begin
    int t;
    logic [31:0] w;
    logic [9:0]  l;
    int          pre, adly;
    rstn = 0; start = 0; base = '0; len = '0; empty = 1; rdata = '0; ack = 0;
    #12;
    check_idle_outputs("reset");
    @(posedge clk); #3 rstn = 1;
    @(posedge clk); #2;

    word_src = '{32'h11111111, 32'h22222222, 32'h33333333};
    run_xfer(10'h010, 10'd3, 3, 0, 0, 0, 1);

    // Empty FIFO at start; the single word arrives 20 cycles later.
    run_xfer(10'h155, 10'd1, 0, 0, 20, 0, 0);

    run_xfer(10'h200, 10'd2, 2, 5, 0, 0, 0);
    run_xfer(10'h3FF, 10'd2, 2, 0, 0, 0, 1);
    run_xfer(10'h0AA, 10'd0, 0, 0, 0, 0, 1);

    // Reset while a write is stalled waiting for ack.
    ack_delay = 1000000;
    w = $urandom;
    fifo_q.push_back(w); model_words.push_back(w); empty = 0;
    exp_addr = 10'h123; cur_len = 2; wr_cnt = 0;
    base = 10'h123; len = 10'd2; start = 1;
    @(posedge clk); #2;
    start = 0; xfer_active = 1;
    t = 0;
    while (!we && t < 50) begin
      @(posedge clk); #2;
      t++;
    end
    check("memwe_before_reset", we, 1);
    @(posedge clk); #3 rstn = 0;
    #1;
    check_idle_outputs("mid_write_reset");
    fifo_q.delete(); pending.delete(); model_words.delete();
    xfer_active = 0; done_exp = 0; ack_delay = 0; empty = 1;
    repeat (2) @(posedge clk);
    #3 rstn = 1;
    @(posedge clk); #2;
    run_xfer(10'h040, 10'd3, 1, 1, 0, 2, 0);

`ifdef FIFOREADER_CHECKSUM_EN
    word_src = '{32'hFFFFFFFF, 32'h00000002};
    run_xfer(10'h050, 10'd2, 2, 0, 0, 0, 1);
    check("checksum_wrap", checksum, 32'h00000001);
    run_xfer(10'h060, 10'd0, 0, 0, 0, 0, 1);
    check("checksum_cleared", checksum, 32'h0);
`endif

    for (int i = 0; i < 30; i++) begin
      l    = 10'($urandom_range(6, 0));
      pre  = $urandom_range(int'(l), 0);
      adly = $urandom_range(3, 0);
      run_xfer(10'($urandom), l, pre, adly, 0, $urandom_range(3, 0), (pre == int'(l)) && (adly == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
